zoom_center_tracker: RTL

// - Upstream feeder of the zoomed address generator.
// - Accumulates the masked-pixel centroid of each camera frame and divides it sequentially.
// - Clamps the centroid so the zoom window stays inside the sensor frame.
// - Publishes center_x_out/center_y_out; the address generator latches them at its own frame start.

---
 rtl/zoom_center_tracker.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/zoom_center_tracker.sv
// zoom_center_tracker
// Accumulates the masked-pixel centroid of each frame, divides it with a
// pair of sequential restoring dividers, clamps it so the zoom window stays
// inside the sensor, and publishes the result as an untorn x/y pair.
// Optional feature macro: SMOOTHING_EN (IIR smoothing of the published center).
module zoom_center_tracker #(
`ifdef SMOOTHING_EN
    parameter int SMOOTH_SHIFT = 2,
`endif
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int ZOOM_HALF_W = 320,
    parameter int ZOOM_HALF_H = 180,
    parameter int MIN_PIXELS  = 64,
    parameter int SUM_W       = 32,
    parameter int CNT_W       = 20
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        pixel_valid_in,
    input  logic        mask_in,
    input  logic        frame_end_in,
    output logic [11:0] center_x_out,
    output logic [10:0] center_y_out,
    output logic        center_valid_out,
    output logic        busy_out,
    output logic        drop_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_CLAMP  = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    localparam logic [11:0] CX_RESET = 12'(H_ACTIVE / 2);
    localparam logic [10:0] CY_RESET = 11'(V_ACTIVE / 2);

    state_t              r_state;
    state_t              w_state_nxt;

    logic [SUM_W-1:0]    r_sum_x;
    logic [SUM_W-1:0]    r_sum_y;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_hit;
    logic [SUM_W-1:0]    w_sum_x_add;
    logic [SUM_W-1:0]    w_sum_y_add;
    logic [CNT_W-1:0]    w_cnt_add;
    logic                w_start;

    logic [SUM_W-1:0]    r_dvd_x;
    logic [SUM_W-1:0]    r_dvd_y;
    logic [SUM_W-1:0]    r_rem_x;
    logic [SUM_W-1:0]    r_rem_y;
    logic [SUM_W-1:0]    r_den;
    logic [5:0]          r_bit_cnt;
    logic [SUM_W:0]      w_rem_x_sh;
    logic [SUM_W:0]      w_rem_y_sh;
    logic [SUM_W:0]      w_rem_x_sub;
    logic [SUM_W:0]      w_rem_y_sub;
    logic                w_ge_x;
    logic                w_ge_y;

    logic [11:0]         w_cx_clamp;
    logic [10:0]         w_cy_clamp;
    logic [11:0]         w_cx_new;
    logic [10:0]         w_cy_new;

    logic [11:0]         r_cx;
    logic [10:0]         r_cy;
    logic                r_valid;
    logic                r_busy;
    logic                r_drop;

    // Accumulator increments, including a masked pixel coincident with frame_end.
    always_comb begin
        w_hit       = pixel_valid_in & mask_in;
        w_sum_x_add = r_sum_x;
        w_sum_y_add = r_sum_y;
        w_cnt_add   = r_cnt;
        if (w_hit) begin
            w_sum_x_add = r_sum_x + SUM_W'(hcount_in);
            w_sum_y_add = r_sum_y + SUM_W'(vcount_in);
            if (r_cnt != {CNT_W{1'b1}}) begin
                w_cnt_add = r_cnt + CNT_W'(1);
            end else begin
                w_cnt_add = r_cnt;
            end
        end else begin
            w_cnt_add = r_cnt;
        end
        w_start = frame_end_in && (r_state == ST_IDLE) &&
                  (w_cnt_add >= CNT_W'(MIN_PIXELS));
    end

    // Per-frame accumulators; cleared on every frame_end, busy or not.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_cnt   <= '0;
        end else if (frame_end_in) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_cnt   <= '0;
        end else begin
            r_sum_x <= w_sum_x_add;
            r_sum_y <= w_sum_y_add;
            r_cnt   <= w_cnt_add;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> DIVIDE -> CLAMP -> UPDATE -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_DIVIDE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (r_bit_cnt == 6'(SUM_W - 1)) begin
                    w_state_nxt = ST_CLAMP;
                end else begin
                    w_state_nxt = ST_DIVIDE;
                end
            end
            ST_CLAMP:  w_state_nxt = ST_UPDATE;
            ST_UPDATE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // One restoring-division step for x and y sharing the same divisor.
    always_comb begin
        w_rem_x_sh  = {r_rem_x, r_dvd_x[SUM_W-1]};
        w_rem_y_sh  = {r_rem_y, r_dvd_y[SUM_W-1]};
        w_rem_x_sub = w_rem_x_sh - {1'b0, r_den};
        w_rem_y_sub = w_rem_y_sh - {1'b0, r_den};
        w_ge_x      = (w_rem_x_sh >= {1'b0, r_den});
        w_ge_y      = (w_rem_y_sh >= {1'b0, r_den});
    end

    // Divider registers: load the snapshot on start, shift one bit per cycle.
    // The dividend register fills with quotient bits as the dividend drains.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_dvd_x   <= '0;
            r_dvd_y   <= '0;
            r_rem_x   <= '0;
            r_rem_y   <= '0;
            r_den     <= '0;
            r_bit_cnt <= 6'd0;
        end else if (w_start) begin
            r_dvd_x   <= w_sum_x_add;
            r_dvd_y   <= w_sum_y_add;
            r_rem_x   <= '0;
            r_rem_y   <= '0;
            r_den     <= SUM_W'(w_cnt_add);
            r_bit_cnt <= 6'd0;
        end else if (r_state == ST_DIVIDE) begin
            r_dvd_x   <= {r_dvd_x[SUM_W-2:0], w_ge_x};
            r_dvd_y   <= {r_dvd_y[SUM_W-2:0], w_ge_y};
            r_rem_x   <= w_ge_x ? w_rem_x_sub[SUM_W-1:0] : w_rem_x_sh[SUM_W-1:0];
            r_rem_y   <= w_ge_y ? w_rem_y_sub[SUM_W-1:0] : w_rem_y_sh[SUM_W-1:0];
            r_bit_cnt <= r_bit_cnt + 6'd1;
        end
    end

    // Clamp the quotients so the zoom window lies inside the sensor.
    always_comb begin
        w_cx_clamp = r_dvd_x[11:0];
        w_cy_clamp = r_dvd_y[10:0];
        if (r_dvd_x < SUM_W'(ZOOM_HALF_W)) begin
            w_cx_clamp = 12'(ZOOM_HALF_W);
        end else if (r_dvd_x > SUM_W'(H_ACTIVE - ZOOM_HALF_W)) begin
            w_cx_clamp = 12'(H_ACTIVE - ZOOM_HALF_W);
        end else begin
            w_cx_clamp = r_dvd_x[11:0];
        end
        if (r_dvd_y < SUM_W'(ZOOM_HALF_H)) begin
            w_cy_clamp = 11'(ZOOM_HALF_H);
        end else if (r_dvd_y > SUM_W'(V_ACTIVE - ZOOM_HALF_H)) begin
            w_cy_clamp = 11'(V_ACTIVE - ZOOM_HALF_H);
        end else begin
            w_cy_clamp = r_dvd_y[10:0];
        end
    end

`ifdef SMOOTHING_EN
    logic signed [12:0] w_dx;
    logic signed [12:0] w_sx;
    logic signed [11:0] w_dy;
    logic signed [11:0] w_sy;

    // IIR step toward the clamped target; never stalls short of it.
    always_comb begin
        w_dx = $signed({1'b0, w_cx_clamp}) - $signed({1'b0, r_cx});
        w_dy = $signed({1'b0, w_cy_clamp}) - $signed({1'b0, r_cy});
        w_sx = w_dx >>> SMOOTH_SHIFT;
        w_sy = w_dy >>> SMOOTH_SHIFT;
        if ((w_sx == 13'sd0) && (w_dx != 13'sd0)) begin
            w_sx = w_dx[12] ? -13'sd1 : 13'sd1;
        end else begin
            w_sx = w_sx;
        end
        if ((w_sy == 12'sd0) && (w_dy != 12'sd0)) begin
            w_sy = w_dy[11] ? -12'sd1 : 12'sd1;
        end else begin
            w_sy = w_sy;
        end
        w_cx_new = r_cx + w_sx[11:0];
        w_cy_new = r_cy + w_sy[10:0];
    end
`else
    // Without smoothing the clamped centroid is published directly.
    always_comb begin
        w_cx_new = w_cx_clamp;
        w_cy_new = w_cy_clamp;
    end
`endif

    // Registered outputs; x and y are written together so they never tear.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cx    <= CX_RESET;
            r_cy    <= CY_RESET;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_valid <= (r_state == ST_CLAMP);
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_drop  <= frame_end_in && (r_state != ST_IDLE);
            if (r_state == ST_CLAMP) begin
                r_cx <= w_cx_new;
                r_cy <= w_cy_new;
            end
        end
    end

    assign center_x_out     = r_cx;
    assign center_y_out     = r_cy;
    assign center_valid_out = r_valid;
    assign busy_out         = r_busy;
    assign drop_out         = r_drop;

endmodule
